// File: rtl/load_seq.sv
// ---------------------------------------------------------------------------
// load_seq: load sequencer between the execute stage and the data memory port.
// Accepts one load request (byte address and width code). It issues one read,
// or two word-aligned reads when the access crosses a 32-bit word boundary.
// It merges the returned words, extracts the addressed byte/halfword/word,
// sign- or zero-extends it and returns the result on a valid/ready handshake.
// Each read has a bounded response timeout.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake (ready only in IDLE)
//   req_addr_i[31:0]          byte address
//   req_width_i[2:0]          000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   mem_req_o/mem_gnt_i       memory read request / grant
//   mem_addr_o[31:0]          word-aligned read address
//   mem_rvalid_i/mem_rdata_i  read response (little-endian word)
//   rsp_valid_o/rsp_ready_i   result handshake
//   rsp_data_o[31:0]          extended load result
//   rsp_err_o                 illegal width, disallowed misalignment or timeout
//   busy_o                    high whenever not IDLE
// ---------------------------------------------------------------------------
module load_seq #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 64
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_width_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned TmoW    = 8;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_WAIT0 = 3'd2,
    S_RD1   = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e          state_q;
  logic [31:0]     addr_q;
  logic [2:0]      width_q;
  logic            cross_q;
  logic [31:0]     lo_q;
  logic [TmoW-1:0] tmo_q;

  logic            req_ready_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;
  logic            busy_q;

  logic            req_legal_c;
  logic [2:0]      req_size_c;
  logic            req_cross_c;

  // Decode the incoming request: legality, access size and word crossing.
  always_comb begin
    req_legal_c = 1'b0;
    req_size_c  = 3'd4;
    case (req_width_i)
      3'b000, 3'b100: begin req_legal_c = 1'b1; req_size_c = 3'd1; end
      3'b001, 3'b101: begin req_legal_c = 1'b1; req_size_c = 3'd2; end
      3'b010:         begin req_legal_c = 1'b1; req_size_c = 3'd4; end
      default:        begin req_legal_c = 1'b0; req_size_c = 3'd4; end
    endcase
    req_cross_c = ({1'b0, req_addr_i[1:0]} + req_size_c) > 3'd4;
  end

  // Shift the merged {hi, lo} doubleword to the addressed byte and extend.
  function automatic logic [31:0] extract(input logic [63:0] dw,
                                          input logic [1:0]  off,
                                          input logic [2:0]  w);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (w)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extract = sh;
      3'b100:  extract = {24'h0, sh[7:0]};
      3'b101:  extract = {16'h0, sh[15:0]};
      default: extract = 32'h0;
    endcase
  endfunction

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      width_q     <= 3'b000;
      cross_q     <= 1'b0;
      lo_q        <= 32'h0;
      tmo_q       <= '0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            addr_q      <= req_addr_i;
            width_q     <= req_width_i;
            cross_q     <= req_cross_c;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (!req_legal_c || (req_cross_c && !ALLOW_MISALIGNED)) begin
              // Rejected without touching memory.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'h0;
            end else begin
              state_q    <= S_RD0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
            end
          end
        end

        S_RD0: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_WAIT0;
          end
        end

        S_WAIT0: begin
          // A response in the final timeout cycle still wins over the abort.
          if (mem_rvalid_i) begin
            lo_q <= mem_rdata_i;
            if (cross_q) begin
              state_q    <= S_RD1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {addr_q[31:2] + 30'd1, 2'b00};
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= extract({32'h0, mem_rdata_i}, addr_q[1:0], width_q);
            end
          end else if (tmo_q == TmoLast) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'h0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        S_RD1: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= S_WAIT1;
          end
        end

        S_WAIT1: begin
          if (mem_rvalid_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= extract({mem_rdata_i, lo_q}, addr_q[1:0], width_q);
          end else if (tmo_q == TmoLast) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= 32'h0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          mem_req_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= 32'h0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule
